// File: rtl/packetizer_rr_arbiter.sv
// Round-robin arbiter feeding a single-flit packetizer: picks one valid requester
// per cycle, starting from the slot after the last winner, into a one-entry output register.
module packetizer_rr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH_IN      = 12,
  parameter int ADDRESS_WIDTH = 4,
  parameter int SRC_WIDTH     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ*WIDTH_IN-1:0]        data_in,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   dst_in,
  input  logic [NUM_REQ-1:0]                 valid_in,
  output logic [NUM_REQ-1:0]                 ready_out,
  output logic [WIDTH_IN-1:0]                data_out,
  output logic [ADDRESS_WIDTH-1:0]           dst_out,
  output logic [SRC_WIDTH-1:0]               src_out,
  output logic                               valid_out,
  input  logic                               ready_in
);

  logic                     load;
  logic                     found;
  logic [SRC_WIDTH-1:0]     ptr;
  logic [SRC_WIDTH-1:0]     win;
  logic [WIDTH_IN-1:0]      win_data;
  logic [ADDRESS_WIDTH-1:0] win_dst;

  assign load = ~valid_out | ready_in;

  // Scan ptr, ptr+1, ... wrapping at NUM_REQ; first valid requester wins.
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    win_dst  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && valid_in[idx]) begin
        found    = 1'b1;
        win      = idx[SRC_WIDTH-1:0];
        win_data = data_in[idx*WIDTH_IN +: WIDTH_IN];
        win_dst  = dst_in[idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
    end
  end

  // Gating with rst keeps every grant void while the block is held in reset.
  always_comb begin
    ready_out = '0;
    if (load && found && !rst) ready_out[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      dst_out   <= '0;
      src_out   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        valid_out <= 1'b1;
        data_out  <= win_data;
        dst_out   <= win_dst;
        src_out   <= win;
        if (win == SRC_WIDTH'(NUM_REQ - 1)) ptr <= '0;
        else                                ptr <= win + 1'b1;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_packetizer_rr_arbiter.sv
// Randomized scoreboard bench for packetizer_rr_arbiter: a spec-level model predicts
// grants and pushes expected packets; a negedge monitor checks what the DUT presents.
module tb_packetizer_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int AW = 4;
  localparam int SW = 2;

  typedef struct {
    logic [W-1:0]  data;
    logic [AW-1:0] dst;
    logic [SW-1:0] src;
  } pkt_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*W-1:0]    data_in;
  logic [N*AW-1:0]   dst_in;
  logic [N-1:0]      valid_in;
  logic [N-1:0]      ready_out;
  logic [W-1:0]      data_out;
  logic [AW-1:0]     dst_out;
  logic [SW-1:0]     src_out;
  logic              valid_out;
  logic              ready_in;

  int   tests = 0;
  int   fails = 0;
  pkt_t sb_q[$];
  pkt_t last_pkt;
  bit   m_valid;
  int   m_ptr;
  bit   mon_en = 1'b0;

  packetizer_rr_arbiter #(.NUM_REQ(N), .WIDTH_IN(W), .ADDRESS_WIDTH(AW), .SRC_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dst_in(dst_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .dst_out(dst_out), .src_out(src_out),
    .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Round-robin rule: first valid index scanning ptr, ptr+1, ... modulo N.
  function automatic int model_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One clock cycle: drive, check grant against the model, predict the next register state.
  task automatic applyStimulus(input logic [N-1:0] v, input logic r, input bit fixed_pattern);
    int   w;
    bit   load;
    bit   next_valid;
    pkt_t p;
    valid_in = v;
    ready_in = r;
    for (int i = 0; i < N; i++) begin
      data_in[i*W +: W]   = fixed_pattern ? W'(12'h100 + i) : W'($urandom);
      dst_in[i*AW +: AW]  = fixed_pattern ? AW'(i + 8) : AW'($urandom);
    end
    #1;
    load       = !m_valid || r;
    w          = model_winner(v, m_ptr);
    next_valid = m_valid;
    if (load && w >= 0) begin
      checkOutput("ready_out", 32'(ready_out), 32'(1 << w));
      p.data = data_in[w*W +: W];
      p.dst  = dst_in[w*AW +: AW];
      p.src  = SW'(w);
      sb_q.push_back(p);
      next_valid = 1'b1;
      m_ptr      = (w + 1) % N;
    end else begin
      checkOutput("ready_out_idle", 32'(ready_out), 32'd0);
      if (load) next_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    m_valid = next_valid;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 0;
    sb_q.delete();
    last_pkt.data = '0;
    last_pkt.dst  = '0;
    last_pkt.src  = '0;
  endtask

  // Monitor: the head of the queue is the packet currently held in the output register.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checkOutput("valid_out", 32'(valid_out), 32'(m_valid));
      if (m_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd1);
        end else begin
          checkOutput("data_out", 32'(data_out), 32'(sb_q[0].data));
          checkOutput("dst_out",  32'(dst_out),  32'(sb_q[0].dst));
          checkOutput("src_out",  32'(src_out),  32'(sb_q[0].src));
          if (ready_in) last_pkt = sb_q.pop_front();
        end
      end else begin
        checkOutput("data_hold", 32'(data_out), 32'(last_pkt.data));
        checkOutput("dst_hold",  32'(dst_out),  32'(last_pkt.dst));
        checkOutput("src_hold",  32'(src_out),  32'(last_pkt.src));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    valid_in = '1;
    ready_in = 1'b1;
    data_in  = '0;
    dst_in   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid_out", 32'(valid_out), 32'd0);
    checkOutput("reset_ready_out", 32'(ready_out), 32'd0);
    checkOutput("reset_src_out",   32'(src_out),   32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // All requesters valid with a fixed pattern: grants 0,1,2,3,0 back to back.
    repeat (5) applyStimulus(4'hF, 1'b1, 1'b1);
    // Align the pointer to 0 after a grant to 3, then single and split requests.
    repeat (3) applyStimulus(4'hF, 1'b1, 1'b1);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b1001, 1'b1, 1'b0);
    applyStimulus(4'b1001, 1'b1, 1'b0);

    // Backpressure with every requester waiting, then release.
    repeat (5) applyStimulus(4'hF, 1'b0, 1'b0);
    repeat (2) applyStimulus(4'hF, 1'b1, 1'b0);

    // Bubble: one request then idle, data must hold; ready_in toggles while idle.
    applyStimulus(4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // Reset mid-stream while the output is stalled.
    applyStimulus(4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    valid_in = 4'hF;
    ready_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_valid_out", 32'(valid_out), 32'd0);
    checkOutput("async_reset_ready_out", 32'(ready_out), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'hF, 1'b1, 1'b0);

    // Randomized traffic with random downstream backpressure.
    for (int c = 0; c < 400; c++)
      applyStimulus(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0), 1'b0);

    repeat (3) applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/packetizer_rr_arbiter.md
Name: packetizer_rr_arbiter

Overview:
Shares one packetizer/NoC fabric port between N requesters, each of which presents a single-flit packet (data + destination). The block is placed directly upstream of the single-flit packetizer. It selects one valid requester per cycle by round-robin and registers the winner in a one-entry output stage. It also forwards the source index so downstream logic can attach per-source information.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH_IN, 12, data width per requester
ADDRESS_WIDTH, 4, NoC destination address width
SRC_WIDTH, 2, width of src_out; must be >= clog2(NUM_REQ)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  NUM_REQ*WIDTH_IN  requester i occupies bits [i*WIDTH_IN +: WIDTH_IN]
dst_in  input  NUM_REQ*ADDRESS_WIDTH  requester i occupies bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
valid_in  input  NUM_REQ  per-requester valid
ready_out  output  NUM_REQ  per-requester ready (grant); at most one bit high
data_out  output  WIDTH_IN  registered winning data
dst_out  output  ADDRESS_WIDTH  registered winning destination
src_out  output  SRC_WIDTH  registered index of winning requester
valid_out  output  1  output register holds a packet
ready_in  input  1  downstream (packetizer) accepts

Behaviour:
- Reset (async assert, sync deassert by user): valid_out=0, data_out=0, dst_out=0, src_out=0, rr pointer ptr=0; ready_out=0 while rst high.
- load = ~valid_out | ready_in. The output register may be written in this cycle.
- Winner w = first i with valid_in[i]=1, scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
- ready_out[w] = load & |valid_in (combinational). All other ready_out bits = 0. When load=0, all ready_out bits = 0.
- A transfer occurs on requester i iff valid_in[i] & ready_out[i]. On a transfer:
  - data_out <= data_in slice w, dst_out <= dst_in slice w, src_out <= w, valid_out <= 1.
  - ptr <= (w==NUM_REQ-1) ? 0 : w+1. The pointer wraps.
- load=1 and no valid_in: valid_out <= 0. data_out/dst_out/src_out hold their previous values. ptr unchanged.
- load=0 (valid_out=1, ready_in=0): all output registers hold stable, ptr unchanged, no requester granted.
- Latency: 1 cycle from grant to valid_out. Throughput: 1 packet/cycle when ready_in is held at 1, with no bubble.
- ptr advances only on a grant. The fairness bound is: a continuously valid requester is granted within NUM_REQ grants.
- Requesters may drop valid_in without being granted. The arbiter is stateless w.r.t. ungranted requests.
- ready_in may toggle while valid_out=0; this has no effect.
- rst asserted mid-transfer: the registered packet is discarded (valid_out=0 immediately). Any requester handshake in that cycle is void.

Test Plan:
- Reset: assert rst with all valid_in=1 -> valid_out=0, ready_out=4'b0000, ptr=0; after release, first grant is ready_out=4'b0001.
- All four valid, ready_in=1 constant, data_in[i]=12'h100+i, dst_in[i]=i+8 -> valid_out from cycle 1; src_out sequence 0,1,2,3,0; data_out 12'h100..12'h103; dst_out 8..11; no bubbles.
- Only requester 2 valid after a grant to 3 (ptr=0) -> ready_out=4'b0100, src_out=2, next ptr=3. Then requesters 0 and 3 valid -> 3 granted before 0.
- Backpressure: valid_out=1, ready_in=0 for 5 cycles with all requesters valid -> ready_out=0, data_out/dst_out/src_out unchanged. ready_in=1 -> same-cycle grant of next requester, no lost packet.
- Bubble: single request, then valid_in=0 with ready_in=1 -> valid_out falls to 0 one cycle after the last transfer. data_out keeps the last value.
- Reset mid-stream: rst pulsed while valid_out=1, ready_in=0 -> valid_out=0 asynchronously; after release, grant restarts at requester 0.
